// File: rtl/crumb_grid_sequencer.sv
// crumb_grid_sequencer: drives the shared control lines of the crumb cell chain.
// Seeds the chain, then loops wait / step / display capture / drain-to-bytes.
module crumb_grid_sequencer #(
  parameter int N_CELLS    = 64,
  parameter int GEN_PERIOD = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [7:0]  seed_data,
  input  logic        seed_valid,
  output logic        seed_ready,
  output logic        crumb_en,
  output logic        crumb_run,
  output logic        crumb_display,
  output logic        crumb_in_shift,
  input  logic        crumb_out_shift,
  input  logic        crumb_disp_bit,
  output logic [7:0]  frame_data,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic        busy,
  output logic [15:0] gen_count
);

  localparam int CW = $clog2(N_CELLS + 1);
  localparam int WW = $clog2(GEN_PERIOD + 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(N_CELLS - 1);
  localparam logic [CW-1:0] ALL_BITS  = CW'(N_CELLS);
  localparam logic [WW-1:0] LAST_WAIT = WW'(GEN_PERIOD - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_RUN_WAIT = 3'd2;
  localparam logic [2:0] S_STEP     = 3'd3;
  localparam logic [2:0] S_DISPLAY  = 3'd4;
  localparam logic [2:0] S_DRAIN    = 3'd5;

  logic [2:0]    r_state;
  logic [7:0]    r_seed_byte;
  logic          r_seed_full;
  logic [2:0]    r_seed_bits;
  logic [CW-1:0] r_bit_cnt;
  logic [WW-1:0] r_wait_cnt;
  logic [15:0]   r_gen_count;
  logic          r_stop_req;
  logic [7:0]    r_frame_byte;
  logic [2:0]    r_frame_bits;
  logic          r_frame_valid;

  logic w_load_shift;
  logic w_drain_shift;
  logic w_seed_take;
  logic w_frame_take;

  assign w_load_shift  = (r_state == S_LOAD) && r_seed_full;
  assign w_drain_shift = (r_state == S_DRAIN) && !r_frame_valid;
  assign w_seed_take   = seed_ready && seed_valid;
  assign w_frame_take  = r_frame_valid && frame_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_seed_byte   <= '0;
      r_seed_full   <= 1'b0;
      r_seed_bits   <= '0;
      r_bit_cnt     <= '0;
      r_wait_cnt    <= '0;
      r_gen_count   <= '0;
      r_stop_req    <= 1'b0;
      r_frame_byte  <= '0;
      r_frame_bits  <= '0;
      r_frame_valid <= 1'b0;
    end else begin
      if (stop) r_stop_req <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_LOAD;
            r_gen_count <= '0;
            r_stop_req  <= stop;
            r_bit_cnt   <= '0;
            r_seed_full <= 1'b0;
            r_seed_bits <= '0;
          end
        end
        S_LOAD: begin
          if (w_seed_take) begin
            r_seed_byte <= seed_data;
            r_seed_full <= 1'b1;
          end else if (r_seed_full) begin
            r_seed_byte <= {1'b0, r_seed_byte[7:1]};
            r_seed_bits <= r_seed_bits + 1'b1;
            if (r_seed_bits == 3'd7) r_seed_full <= 1'b0;
            if (r_bit_cnt == LAST_BIT) begin
              r_bit_cnt  <= '0;
              r_wait_cnt <= '0;
              r_state    <= S_RUN_WAIT;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        S_RUN_WAIT: begin
          if (r_stop_req) begin
            r_stop_req <= 1'b0;
            r_state    <= S_IDLE;
          end else if (r_wait_cnt == LAST_WAIT) begin
            r_wait_cnt <= '0;
            r_state    <= S_STEP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        S_STEP: begin
          r_gen_count <= r_gen_count + 16'd1;
          r_state     <= S_DISPLAY;
        end
        S_DISPLAY: begin
          r_frame_bits <= '0;
          r_state      <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_frame_take) begin
            r_frame_valid <= 1'b0;
            if (r_bit_cnt == ALL_BITS) begin
              r_bit_cnt  <= '0;
              r_wait_cnt <= '0;
              r_state    <= S_RUN_WAIT;
            end
          end else if (!r_frame_valid) begin
            // first captured bit ends up in bit0 after eight shifts
            r_frame_byte <= {crumb_disp_bit, r_frame_byte[7:1]};
            r_frame_bits <= r_frame_bits + 1'b1;
            r_bit_cnt    <= r_bit_cnt + 1'b1;
            if (r_frame_bits == 3'd7) r_frame_valid <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign seed_ready     = (r_state == S_LOAD) && !r_seed_full;
  assign crumb_en       = w_load_shift || w_drain_shift || (r_state == S_STEP);
  assign crumb_run      = (r_state == S_STEP);
  assign crumb_display  = (r_state == S_DISPLAY);
  assign crumb_in_shift = w_load_shift  ? r_seed_byte[0] :
                          w_drain_shift ? crumb_out_shift : 1'b0;
  assign frame_data     = r_frame_byte;
  assign frame_valid    = r_frame_valid;
  assign busy           = (r_state != S_IDLE);
  assign gen_count      = r_gen_count;

endmodule

// File: tb/tb_crumb_grid_sequencer.sv
// tb_crumb_grid_sequencer: directed checks with a 16-crumb chain model.
// Seed load is table driven; generations, stall, stop and reset are hand sequences.
module tb_crumb_grid_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic [7:0] seed_data = '0;
  logic seed_valid = 1'b0;
  logic seed_ready;
  logic crumb_en, crumb_run, crumb_display, crumb_in_shift;
  logic crumb_out_shift, crumb_disp_bit;
  logic [7:0] frame_data;
  logic frame_valid;
  logic frame_ready = 1'b0;
  logic busy;
  logic [15:0] gen_count;

  int errors = 0;
  int checks = 0;

  crumb_grid_sequencer #(.N_CELLS(16), .GEN_PERIOD(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .seed_data(seed_data), .seed_valid(seed_valid), .seed_ready(seed_ready),
    .crumb_en(crumb_en), .crumb_run(crumb_run), .crumb_display(crumb_display),
    .crumb_in_shift(crumb_in_shift), .crumb_out_shift(crumb_out_shift),
    .crumb_disp_bit(crumb_disp_bit), .frame_data(frame_data),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .busy(busy), .gen_count(gen_count)
  );

  always #5 clk = ~clk;

  // chain model: state chain shifts toward [15], display chain shifts alongside
  logic [15:0] m_s = '0;
  logic [15:0] m_d = '0;
  always @(posedge clk) begin
    if (crumb_en && !crumb_run) begin
      m_s <= {m_s[14:0], crumb_in_shift};
      m_d <= {m_d[14:0], 1'b0};
    end else if (crumb_en && crumb_run) begin
      m_s <= {m_s[14:0], m_s[15]} ^ m_s;
    end
    if (crumb_display) m_d <= m_s;
  end
  assign crumb_out_shift = m_s[15];
  assign crumb_disp_bit  = m_d[15];

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rdy;
    logic       en;
    logic       in;
  } vec_t;

  vec_t tbl[20];
  logic pat[16] = '{1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0};
  logic [7:0] exp_b[2];
  logic [15:0] snap;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic drain(input int stall, input bit do_stop);
    int nb = 0;
    int en_cnt = 0;
    int cyc = 0;
    logic [7:0] held;
    bit bad;
    frame_ready = (stall == 0);
    while (nb < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      stop = 1'b0;
      if (crumb_en) en_cnt++;
      if (frame_valid) begin
        if (nb == 0 && stall > 0) begin
          held = frame_data;
          bad = 1'b0;
          repeat (stall) begin
            @(negedge clk);
            cyc++;
            if (crumb_en || !frame_valid || frame_data !== held) bad = 1'b1;
          end
          check("stall_hold", 32'(bad), 32'd0);
          frame_ready = 1'b1;
        end
        check($sformatf("frame_byte%0d", nb), 32'(frame_data), 32'(exp_b[nb]));
        nb++;
        if (do_stop && nb == 1) stop = 1'b1;
      end
    end
    check("drain_bytes", nb, 2);
    check("drain_en_cycles", en_cnt, 16);
  endtask

  task automatic generation(input int g, input int stall, input bit do_stop);
    int q = 0;
    while (q < 50) begin
      @(negedge clk);
      if (crumb_run) break;
      if (crumb_en || crumb_display) q = 100;
      q++;
    end
    check("wait_cycles", q, 4);
    check("step_lines", {crumb_en, crumb_display}, 2'b10);
    @(negedge clk);
    check("display_lines", {crumb_en, crumb_run, crumb_display}, 3'b001);
    check("gen_count", gen_count, g);
    snap = m_s;
    for (int j = 0; j < 2; j++)
      for (int b = 0; b < 8; b++)
        exp_b[j][b] = snap[15 - (8 * j + b)];
    drain(stall, do_stop);
    check("state_restored", m_s, snap);
  endtask

  initial begin
    for (int i = 0; i < 20; i++) tbl[i] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 8; k++) begin
      tbl[1 + k]  = '{1'b0, 8'h00, 1'b0, 1'b1, pat[k]};
      tbl[12 + k] = '{1'b0, 8'h00, 1'b0, 1'b1, pat[8 + k]};
    end

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_outputs",
          {seed_ready, crumb_en, crumb_run, crumb_display, crumb_in_shift,
           frame_data, frame_valid, gen_count}, 32'd0);
    check("reset_busy", busy, 0);

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      seed_valid = tbl[i].v;
      seed_data  = tbl[i].d;
      #1;
      check($sformatf("load_row%0d", i),
            {seed_ready, crumb_en, crumb_in_shift, crumb_run, busy},
            {tbl[i].rdy, tbl[i].en, tbl[i].in, 1'b0, 1'b1});
    end
    seed_valid = 1'b0;

    generation(1, 0, 1'b0);
    generation(2, 10, 1'b0);
    generation(3, 0, 1'b1);
    @(negedge clk);
    check("stop_run_wait_busy", busy, 1);
    @(negedge clk);
    check("stop_idle_busy", busy, 0);
    check("stop_gen_count", gen_count, 3);

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seed_valid = 1'b1;
    seed_data  = 8'hFF;
    repeat (4) @(negedge clk);
    check("pre_reset_shift", {crumb_en, crumb_in_shift}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {seed_ready, crumb_en, crumb_run, crumb_display, crumb_in_shift,
           frame_data, frame_valid, gen_count}, 32'd0);
    check("async_reset_busy", busy, 0);
    seed_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
